// File: rtl/pipe_out_source.sv
// Pattern data source for pipe-out testing: generates WIDTH-bit words on host reads,
// tracks a throttled virtual FIFO level and reports word/block counts and underflow.
module pipe_out_source #(
   parameter int WIDTH       = 32,
   parameter int BLOCK_WORDS = 1024,
   parameter int DEPTH       = 65535,
   parameter int LEVEL_BITS  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pipe_out_read,
   output logic [WIDTH-1:0]      pipe_out_data,
   output logic                  pipe_out_ready,
   input  logic                  throttle_set,
   input  logic [31:0]           throttle_val,
   input  logic [31:0]           fixed_pattern,
   input  logic [2:0]            pattern,
   output logic [LEVEL_BITS-1:0] level,
   output logic [31:0]           word_count,
   output logic [31:0]           block_count,
   output logic                  underflow
);

   localparam int                    LANES     = WIDTH / 32;
   localparam logic [LEVEL_BITS-1:0] DEPTH_L   = LEVEL_BITS'(DEPTH);
   localparam logic [LEVEL_BITS-1:0] BLOCK_L   = LEVEL_BITS'(BLOCK_WORDS);
   localparam logic [31:0]           BLK_LAST  = 32'(BLOCK_WORDS - 1);
   localparam logic [31:0]           LFSR_TAPS = 32'h80200003;

   logic [31:0]      word_index;
   logic [31:0]      lfsr;
   logic [31:0]      throttle;
   logic [31:0]      word_in_block;
   logic [WIDTH-1:0] next_word;

   // Each lane is computed from the pre-advance generator state.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      localparam logic [31:0] KOFF = 32'(k);
      localparam int          ROT  = 8 * k;
      logic [63:0] rot_dbl;
      logic [31:0] lane;

      assign rot_dbl = {lfsr, lfsr} << ROT;

      always_comb begin
         lane = '0;
         case (pattern)
            3'd0:    lane = word_index * 32'(LANES) + KOFF;
            3'd1:    lane = rot_dbl[63:32];
            3'd2:    lane = 32'd1 << word_index[4:0];
            3'd3:    lane = fixed_pattern;
            3'd4:    lane = word_index[0] ? ~fixed_pattern : fixed_pattern;
            default: lane = '0;
         endcase
      end

      assign next_word[32*k +: 32] = lane;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_out_data  <= '0;
         pipe_out_ready <= 1'b0;
         level          <= '0;
         word_count     <= '0;
         block_count    <= '0;
         underflow      <= 1'b0;
         word_index     <= '0;
         word_in_block  <= '0;
         lfsr           <= (fixed_pattern != 32'd0) ? fixed_pattern : 32'h00000001;
         throttle       <= throttle_val;
      end else begin
         throttle       <= throttle_set ? throttle_val : {throttle[0], throttle[31:1]};
         pipe_out_ready <= (level >= BLOCK_L);

         // throttle[0] is this cycle's virtual write; a read+write pair cancels.
         case ({pipe_out_read, throttle[0]})
            2'b01: begin
               if (level != DEPTH_L) level <= level + 1'b1;
            end
            2'b10: begin
               if (level == '0) underflow <= 1'b1;
               else             level     <= level - 1'b1;
            end
            default: ;
         endcase

         if (pipe_out_read) begin
            pipe_out_data <= next_word;
            word_index    <= word_index + 32'd1;
            lfsr          <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 32'd0);
            word_count    <= word_count + 32'd1;
            if (word_in_block == BLK_LAST) begin
               word_in_block <= '0;
               block_count   <= block_count + 32'd1;
            end else begin
               word_in_block <= word_in_block + 32'd1;
            end
         end
      end
   end

endmodule

// File: doc/pipe_out_source.md
# pipe_out_source

Parametrised pseudorandom/pattern data source for Pipe Out and Block-Throttled Pipe Out verification. Generates WIDTH-bit words, assembled from 32-bit lanes, from a self-contained pattern engine. Gates the host with a throttled virtual FIFO level compared against a configurable block size. Exposes word/block counters and a sticky underflow flag so host software can check transfer integrity. Sits between the FrontPanel pipe endpoint and the test register bank, alongside the pipe-in checker.

## Interface
- WIDTH, 32: data width; must be a multiple of 32 (32, 64, 128 supported); LANES = WIDTH/32.
- BLOCK_WORDS, 1024: level threshold for pipe_out_ready; must be ≥1 and ≤ DEPTH.
- DEPTH, 65535: virtual FIFO saturation level; must be ≤ 2^LEVEL_BITS−1.
- LEVEL_BITS, 16: width of the level counter.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- pipe_out_read  in  1  host read strobe, one word per cycle high.
- pipe_out_data  out  WIDTH  generated word (registered).
- pipe_out_ready  out  1  registered; high when level ≥ BLOCK_WORDS.
- throttle_set  in  1  load throttle_val into the throttle ring.
- throttle_val  in  32  throttle ring value.
- fixed_pattern  in  32  fixed word / LFSR seed.
- pattern  in  3  pattern mode, sampled on every read.
- level  out  LEVEL_BITS  current virtual FIFO level.
- word_count  out  32  reads since reset, wraps at 2^32.
- block_count  out  32  completed blocks of BLOCK_WORDS reads, wraps.
- underflow  out  1  sticky; set on a read at level 0 with no write that cycle.

## Operation
- Generator state: word_index (32 b) and lfsr (32 b). Both advance on every read, regardless of mode.
- LFSR step: lfsr ← (lfsr>>1) ^ (lfsr[0] ? 32'h80200003 : 0).
- Lane k (k = 0 is bits [31:0]) of the word produced by the current read, using pre-advance state:
  - 0 count: word_index·LANES + k.
  - 1 lfsr: lfsr rotated left by 8k.
  - 2 walking one: 1 << (word_index mod 32), same in all lanes.
  - 3 fixed: fixed_pattern.
  - 4 alternating: fixed_pattern when word_index is even, ~fixed_pattern when odd.
  - 5–7: zero.
- Throttle ring rotates right each cycle: throttle ← {throttle[0], throttle[31:1]}. throttle_set instead loads throttle_val and takes priority over rotation. throttle[0] is the virtual write enable for the cycle.
- Level update on {read, throttle[0]}:
  - 01: +1, saturating at DEPTH.
  - 10: −1, held at 0; if level was 0, set underflow.
  - 00 or 11: unchanged, including 11 at level 0 (no underflow).
- Block counter: word_in_block counts reads 0..BLOCK_WORDS−1. On the read that completes a block, word_in_block wraps to 0 and block_count increments.
- Mode changes take effect on the next read and do not reset generator state.

## Timing
- Reset values:
  - pipe_out_data 0, pipe_out_ready 0, level 0, word_count 0, block_count 0, underflow 0, word_index 0.
  - lfsr = fixed_pattern if nonzero, else 32'h00000001.
  - throttle = throttle_val.
- Data latency: the word for read n appears on pipe_out_data one edge after the cycle pipe_out_read is sampled high. The value is held until the next read.
- pipe_out_ready is registered from level, so it lags level by one edge. Reads are not blocked when ready is low; a read at level 0 only sets underflow.
- level, word_count and block_count update on the same edge as the read/write.
- Reset asserted mid-transfer takes effect at the next edge: all state returns to reset values, and any read in that cycle is discarded.
- Counter wrap-around at 2^32 is silent.

## Test plan
- WIDTH=64, BLOCK_WORDS=256, throttle_val=32'hFFFFFFFF, no reads:
  - level reaches 256 at the 256th edge after reset release; pipe_out_ready rises at edge 257.
  - level saturates at DEPTH and holds there.
- Mode 0, WIDTH=64, three reads: pipe_out_data = 64'h00000001_00000000, then 64'h00000003_00000002, then 64'h00000005_00000004, each one edge after its read.
- Mode 1, fixed_pattern=0 at reset: first word lane0 = 32'h00000001; second word lane0 = 32'h80200003.
  - Repeat with fixed_pattern=32'hDEADBEEF: first word lane0 = 32'hDEADBEEF.
- throttle_val=32'h00000001, reads continuous from level 0:
  - underflow sets on the first read cycle with throttle[0]=0 and stays set.
  - The cycle with read=1 and throttle[0]=1 leaves level unchanged.
- BLOCK_WORDS=4, 9 reads: block_count = 2, word_count = 9.
  - Assert reset after read 9: all counters return to 0, pipe_out_ready = 0, underflow = 0.
- Mode 4, fixed_pattern=32'h12345678: words alternate 32'h12345678 / 32'hEDCBA987.
  - throttle_set mid-run reloads the ring in the next cycle; rotation resumes the following cycle.
